// File: rtl/uart_fsm_tx.sv
// Free-running 8N1 UART transmitter: idle gap, start bit, 8 data bits LSB first, stop bit, Done pulse.
// Outputs are registered from the current state, so the line lags the state register by one cycle.
module uart_fsm_tx #(
   parameter int CLKS_PER_BIT = 8,
   parameter int IDLE_CYCLES  = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] datain,
   output logic       x,
   output logic       Done
);

   localparam int MAXC = (CLKS_PER_BIT > IDLE_CYCLES) ? CLKS_PER_BIT : IDLE_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] BITLAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] IDLELAST = CW'(IDLE_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t        state, nextstate;
   logic [CW-1:0] cnt, nextcnt;
   logic [2:0]    idx, nextidx;
   logic [7:0]    shreg;
   logic          load;
   logic          xnext, donenext;

   // State, counters and output flops; the byte is captured only when IDLE hands over to START
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         shreg <= '0;
         x     <= 1'b1;
         Done  <= 1'b0;
      end else begin
         state <= nextstate;
         cnt   <= nextcnt;
         idx   <= nextidx;
         if (load)
            shreg <= datain;
         x     <= xnext;
         Done  <= donenext;
      end
   end

   // Next-state logic; every state change clears the cycle counter
   always_comb begin
      nextstate = state;
      nextcnt   = cnt + 1'b1;
      nextidx   = idx;
      load      = 1'b0;
      xnext     = 1'b1;
      donenext  = 1'b0;
      case (state)
         IDLE: begin
            if (cnt == IDLELAST) begin
               nextstate = START;
               nextcnt   = '0;
               load      = 1'b1;
            end
         end
         START: begin
            xnext = 1'b0;
            if (cnt == BITLAST) begin
               nextstate = DATA;
               nextcnt   = '0;
               nextidx   = '0;
            end
         end
         DATA: begin
            xnext = shreg[idx];
            if (cnt == BITLAST) begin
               nextcnt = '0;
               nextidx = idx + 3'd1;
               if (idx == 3'd7)
                  nextstate = STOP;
            end
         end
         STOP: begin
            if (cnt == BITLAST) begin
               nextstate = DONE;
               nextcnt   = '0;
            end
         end
         DONE: begin
            donenext  = 1'b1;
            nextstate = IDLE;
            nextcnt   = '0;
         end
         default: begin
            nextstate = IDLE;
            nextcnt   = '0;
            nextidx   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_fsm_tx.sv
// Scoreboard bench for uart_fsm_tx: expected {x,Done} per cycle is queued when a frame is requested
// and popped every cycle; one instance uses defaults, the other the one-cycle-per-state corner.
module tb_uart_fsm_tx;

   logic       clk;
   logic       rsta, rstb;
   logic [7:0] dataina, datainb;
   logic       xa, donea, xb, doneb;

   logic [1:0] qa[$];
   logic [1:0] qb[$];
   int         checks;
   int         fails;
   int         cyc;

   uart_fsm_tx duta (
      .clk    (clk),
      .rst    (rsta),
      .datain (dataina),
      .x      (xa),
      .Done   (donea)
   );

   uart_fsm_tx #(.CLKS_PER_BIT(1), .IDLE_CYCLES(1)) dutb (
      .clk    (clk),
      .rst    (rstb),
      .datain (datainb),
      .x      (xb),
      .Done   (doneb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [1:0] got, input logic [1:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got x/Done=%b, expected %b", tag, got, exp);
      end
   endtask

   // Builds the line waveform of one frame from the framing rules and queues its first len cycles
   task automatic applyStimulus(input bit sel, input logic [7:0] d, input int len);
      logic [1:0] f[$];
      int cpb;
      int idl;
      cpb = sel ? 1 : 8;
      idl = sel ? 1 : 8;
      repeat (idl) f.push_back(2'b10);
      repeat (cpb) f.push_back(2'b00);
      for (int i = 0; i < 8; i++)
         repeat (cpb) f.push_back({d[i], 1'b0});
      repeat (cpb) f.push_back(2'b10);
      f.push_back(2'b11);
      if (len < 0)
         len = f.size();
      for (int i = 0; i < len; i++) begin
         if (sel) qb.push_back(f[i]);
         else     qa.push_back(f[i]);
      end
      if (sel) datainb = d;
      else     dataina = d;
   endtask

   task automatic runCycles(input int n, input bit sel);
      logic [1:0] got;
      logic [1:0] exp;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
         got = sel ? {xb, doneb} : {xa, donea};
         if ((sel ? qb.size() : qa.size()) == 0) begin
            checkOutput($sformatf("%s_empty_c%0d", sel ? "b" : "a", cyc), got, ~got);
         end else begin
            exp = sel ? qb.pop_front() : qa.pop_front();
            checkOutput($sformatf("%s_c%0d", sel ? "b" : "a", cyc), got, exp);
         end
         cyc++;
      end
   endtask

   initial begin
      checks  = 0;
      fails   = 0;
      rsta    = 1'b1;
      rstb    = 1'b1;
      dataina = 8'hAA;
      datainb = 8'hFF;

      // Reset held for three edges
      cyc = -3;
      repeat (3) qa.push_back(2'b10);
      runCycles(3, 1'b0);

      // Frame 1 with 0xAA; datain switched to 0xCC mid-frame, which only frame 2 may carry
      rsta = 1'b0;
      cyc  = 0;
      applyStimulus(1'b0, 8'hAA, -1);
      runCycles(41, 1'b0);
      applyStimulus(1'b0, 8'hCC, -1);
      runCycles(137, 1'b0);

      // Frame 3 aborted by a one-cycle reset during cycle 50, then a clean restart
      cyc = 0;
      applyStimulus(1'b0, 8'hCC, 51);
      runCycles(51, 1'b0);
      rsta = 1'b1;
      qa.push_back(2'b10);
      dataina = 8'hAA;
      runCycles(1, 1'b0);
      rsta = 1'b0;
      cyc  = 0;
      applyStimulus(1'b0, 8'hAA, -1);
      runCycles(89, 1'b0);

      // Minimal timing instance: every state lasts one cycle, 12-cycle period
      cyc = -1;
      qb.push_back(2'b10);
      runCycles(1, 1'b1);
      rstb = 1'b0;
      applyStimulus(1'b1, 8'hFF, -1);
      applyStimulus(1'b1, 8'hFF, -1);
      runCycles(24, 1'b1);

      checkOutput("a_queue_left", 2'(qa.size() > 0), 2'b00);
      checkOutput("b_queue_left", 2'(qb.size() > 0), 2'b00);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
